rmux_rr_arbiter: RTL



---
 rtl/rmux_rr_arbiter_pkg.sv | 47 ++++
 rtl/rmux_rr_arbiter_if.sv | 35 +++
 rtl/rmux_rr_arbiter_pick.sv | 29 ++
 rtl/rmux_rr_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/rmux_rr_arbiter_pkg.sv
// Shared types and helpers for the routing-mux round-robin arbiter family.
//   arb_state_e : IDLE (arbitrating) / LOCK (path owned by one source)
//   sel_width() : select width for an n-input mux, never less than 1 bit
//   rr_pick()   : rotate-priority search, first set bit at or above ptr,
//                 wrapping modulo n; returns {found, idx}
package rmux_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Widest requester vector the helpers handle (legal N_REQ is 2..16).
    localparam int MAX_REQ    = 16;
    localparam int PICK_IDX_W = 4;

    typedef struct packed {
        logic                  found;
        logic [PICK_IDX_W-1:0] idx;
    } pick_t;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Bits at or above n in vec are ignored; ptr must be below n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] vec,
                                      input int ptr, input int n);
        pick_t res;
        int    j;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n && !res.found) begin
                j = ptr + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (vec[j]) begin
                    res.found = 1'b1;
                    res.idx   = j[PICK_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rmux_rr_arbiter_if.sv
// Handshake bundle between N_REQ packet sources, the arbiter and the
// single downstream routing path.
//   req_valid/req_last/req_data : per-source beats (source i at [i*DATA_W +: DATA_W])
//   req_ready                   : per-source accept
//   out_valid/out_last/out_data : muxed beat toward the routing resource
//   out_ready                   : downstream accept
// Valid/ready: a beat moves on a rising clk edge where valid and ready are
// both high. A source holds data/last stable while valid is high and ready
// is low; it may drop valid before the beat moves (that counts toward the
// stall timeout when it owns the path). Ready never depends on a future
// cycle, only on the current owner and out_ready.
// Modports: slave = arbiter side, master = sources + downstream side.
interface rmux_rr_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    out_valid;
    logic                    out_last;
    logic [DATA_W-1:0]       out_data;
    logic                    out_ready;

    modport slave (
        input  req_valid, req_last, req_data, out_ready,
        output req_ready, out_valid, out_last, out_data
    );

    modport master (
        output req_valid, req_last, req_data, out_ready,
        input  req_ready, out_valid, out_last, out_data
    );
endinterface

// File: rtl/rmux_rr_arbiter_pick.sv
// Combinational rotate-priority encoder: returns the first set bit of req
// searching upward from ptr and wrapping at N_REQ-1 -> 0. Usable by any
// round-robin routing scheduler.
//   req   : request vector
//   ptr   : search start (must be < N_REQ)
//   idx   : winning index, valid when found
//   found : any request set
module rmux_rr_pick
    import rmux_arb_pkg::*;
#(
    parameter  int N_REQ = 2,
    localparam int SEL_W = sel_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);
    logic [MAX_REQ-1:0] vec;
    pick_t              res;

    always_comb begin
        vec              = '0;
        vec[N_REQ-1:0]   = req;
        res              = rr_pick(vec, int'(ptr), N_REQ);
        idx              = SEL_W'(res.idx);
        found            = res.found;
    end
endmodule

// File: rtl/rmux_rr_arbiter.sv
// Round-robin arbiter in front of an N_REQ:1 routing mux. In IDLE it
// registers the next winner into sel (one arbitration cycle, no transfer);
// in LOCK the mux path is combinational and stays with that source until its
// last beat moves or it holds valid low for STALL_MAX cycles.
//   clk, rst_n  : clock, synchronous active-low reset
//   bus         : sources/downstream handshake (slave modport)
//   sel         : registered mux select
//   busy        : high while LOCK
//   stall_err   : high for the single cycle in which a stall timeout releases
//   dbg_state   : FSM state
//   dbg_rr_ptr  : round-robin search start
module rmux_rr_arbiter
    import rmux_arb_pkg::*;
#(
    parameter  int N_REQ     = 2,
    parameter  int DATA_W    = 8,
    parameter  int STALL_MAX = 15,
    localparam int SEL_W     = sel_width(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    rmux_rr_arbiter_if.slave   bus,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               stall_err,
    output arb_state_e         dbg_state,
    output logic [SEL_W-1:0]   dbg_rr_ptr
);
    localparam int                CNT_W     = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);
    localparam logic [CNT_W-1:0]  STALL_LIM = CNT_W'(STALL_MAX);

    arb_state_e        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [SEL_W-1:0]  pick_idx;
    logic              pick_found;
    logic              sel_valid;
    logic              sel_last;
    logic              stall_hit;
    logic [SEL_W-1:0]  sel_next_ptr;

    logic [N_REQ-1:0]  req_ready_c;
    logic              out_valid_c;
    logic              out_last_c;
    logic [DATA_W-1:0] out_data_c;

    rmux_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign sel_valid    = bus.req_valid[sel_q];
    assign sel_last     = bus.req_last[sel_q];
    // Timeout fires on the cycle after the counter has saturated, while the
    // owner is still silent; STALL_MAX == 0 turns it off entirely.
    assign stall_hit    = (STALL_MAX > 0) && (state_q == LOCK) && !sel_valid
                          && (stall_cnt_q == STALL_LIM);
    // Explicit wrap so non-power-of-two N_REQ never yields an index >= N_REQ.
    assign sel_next_ptr = (int'(sel_q) == N_REQ - 1) ? '0 : sel_q + SEL_W'(1);

    // Routing datapath: only the owner sees out_ready, and only in LOCK.
    always_comb begin
        req_ready_c = '0;
        out_valid_c = 1'b0;
        out_last_c  = 1'b0;
        out_data_c  = '0;
        if (state_q == LOCK) begin
            out_valid_c        = sel_valid;
            out_last_c         = sel_last;
            out_data_c         = bus.req_data[int'(sel_q)*DATA_W +: DATA_W];
            req_ready_c[sel_q] = bus.out_ready;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = LOCK;
                    sel_d       = pick_idx;
                    stall_cnt_d = '0;
                end
            end
            LOCK: begin
                if (sel_valid) begin
                    // Backpressure keeps valid high, so it never counts as a stall.
                    stall_cnt_d = '0;
                    if (bus.out_ready && sel_last) begin
                        state_d  = IDLE;
                        rr_ptr_d = sel_next_ptr;
                    end
                end else if (stall_hit) begin
                    state_d     = IDLE;
                    rr_ptr_d    = sel_next_ptr;
                    stall_cnt_d = '0;
                end else if (stall_cnt_q != STALL_LIM) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            rr_ptr_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_last  = out_last_c;
    assign bus.out_data  = out_data_c;

    assign sel        = sel_q;
    assign busy       = (state_q == LOCK);
    assign stall_err  = stall_hit;
    assign dbg_state  = state_q;
    assign dbg_rr_ptr = rr_ptr_q;
endmodule
